spi_flash_read_controller: RTL

- Sequences SPI READ (0x03) transactions to the boot/program flash when the 6809 reads the flash window (0x3000–0x3FFF).
- Stretches the CPU cycle via MRDY until the byte is returned.
- Arbitrates the shared SPI pins with the FT2232 programmer, which always wins.
- Sits between the address decoder's `spi_ce` output, the 6809 data bus mux and the flash pins.

---
 rtl/spi_flash_read_controller.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_read_controller.sv
// SPI READ (0x03) sequencer for the 6809 flash window: stretches the CPU cycle via MRDY
// until the byte returns, and yields the SPI pins whenever the FT2232 programmer owns the flash.
module spi_flash_read_controller #(
    parameter int unsigned CLK_DIV    = 2,
    parameter logic [23:0] FLASH_BASE = 24'h000000,
    parameter logic [7:0]  READ_CMD   = 8'h03
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_spi_ce,
    input  logic        i_rw,
    input  logic [11:0] i_address,
    input  logic        i_FT_CS,
    input  logic        i_spi_miso,
    output logic        o_spi_cs_n,
    output logic        o_spi_sck,
    output logic        o_spi_mosi,
    output logic        o_spi_oe,
    output logic [7:0]  o_data,
    output logic        o_data_valid,
    output logic        o_mrdy,
    output logic        o_busy
);

    typedef enum logic [2:0] {
        IDLE,
        ARB_WAIT,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        DONE
    } state_e;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [5:0] BIT_LAST = 6'd39;

    state_e      state_q, state_d;
    logic [1:0]  ft_sync_q;
    logic [7:0]  div_q, div_d;
    logic [5:0]  bit_q, bit_d;
    logic        phase_q, phase_d;
    logic [39:0] shift_q, shift_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        cs_n_q, cs_n_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic        oe_q, oe_d;
    logic        busy_q, busy_d;

    logic        req;
    logic        ft_own;
    logic        div_last;
    logic        active_q;
    logic        start;
    logic [23:0] flash_addr;

    assign req        = i_spi_ce & i_rw;
    assign ft_own     = ~ft_sync_q[1];
    assign div_last   = (div_q == DIV_LAST);
    assign active_q   = (state_q == CS_SETUP) || (state_q == SHIFT) || (state_q == CS_HOLD);
    assign flash_addr = FLASH_BASE + {12'h000, i_address};

    // State register; the datapath and all pin outputs are registered alongside it.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (i_reset) begin
            state_q   <= IDLE;
            ft_sync_q <= 2'b11;
            div_q     <= '0;
            bit_q     <= '0;
            phase_q   <= 1'b0;
            shift_q   <= '0;
            rx_q      <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            cs_n_q    <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ft_sync_q <= {ft_sync_q[0], i_FT_CS};
            div_q     <= div_d;
            bit_q     <= bit_d;
            phase_q   <= phase_d;
            shift_q   <= shift_d;
            rx_q      <= rx_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            cs_n_q    <= cs_n_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic; aborts override normal sequencing, CPU abort beats FT2232 preemption.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ft_own ? ARB_WAIT : CS_SETUP;
                end
            end
            ARB_WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (!ft_own) begin
                    state_d = CS_SETUP;
                end
            end
            CS_SETUP: begin
                if (div_last) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (div_last && phase_q && (bit_q == BIT_LAST)) begin
                    state_d = CS_HOLD;
                end
            end
            CS_HOLD: begin
                if (div_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (active_q) begin
            if (!req) begin
                state_d = IDLE;
            end else if (ft_own) begin
                state_d = ARB_WAIT;
            end
        end
    end

    // Datapath: SCK phase timing, 40-bit MOSI frame, MISO capture and result load.
    always_comb begin
        start   = (state_d == CS_SETUP) && (state_q != CS_SETUP);
        div_d   = ((state_d != state_q) || div_last) ? 8'd0 : div_q + 8'd1;
        bit_d   = bit_q;
        phase_d = phase_q;
        shift_d = shift_q;
        rx_d    = rx_q;
        data_d  = data_q;
        valid_d = 1'b0;

        if (start) begin
            shift_d = {READ_CMD, flash_addr, 8'h00};
            bit_d   = '0;
            phase_d = 1'b0;
        end else if ((state_q == SHIFT) && (state_d == SHIFT) && div_last) begin
            if (!phase_q) begin
                phase_d = 1'b1;
                rx_d    = {rx_q[6:0], i_spi_miso};
            end else begin
                phase_d = 1'b0;
                shift_d = {shift_q[38:0], 1'b0};
                bit_d   = bit_q + 6'd1;
            end
        end

        if ((state_q == CS_HOLD) && (state_d == DONE)) begin
            data_d  = rx_q;
            valid_d = 1'b1;
        end
    end

    // Pin outputs follow the state being entered, so an abort releases the pins the next cycle.
    always_comb begin
        busy_d = (state_d == CS_SETUP) || (state_d == SHIFT) || (state_d == CS_HOLD);
        cs_n_d = ~busy_d;
        oe_d   = busy_d;
        sck_d  = (state_d == SHIFT) && phase_d;
        mosi_d = busy_d && shift_d[39];
    end

    assign o_mrdy       = i_reset | ~(req & (state_q != DONE));
    assign o_spi_cs_n   = cs_n_q;
    assign o_spi_sck    = sck_q;
    assign o_spi_mosi   = mosi_q;
    assign o_spi_oe     = oe_q;
    assign o_data       = data_q;
    assign o_data_valid = valid_q;
    assign o_busy       = busy_q;

endmodule
